// File: rtl/csb_seq.sv
// csb_seq: fetches multi-word commands, streams operand beats to one of N_ENG engines, starts it and waits for done with timeout
module csb_seq #(
   parameter int DW = 32,
   parameter int N_ENG = 4,
   parameter int CMD_WORDS = 5,
   parameter int TMO_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             op_en,
   input  logic [DW-1:0]    cmd,
   input  logic             cmd_empty,
   output logic             cmd_rd_en,
   input  logic [DW-1:0]    opd_data,
   input  logic             opd_valid,
   output logic             opd_ready,
   output logic [DW-1:0]    eng_data,
   output logic [N_ENG-1:0] eng_valid,
   output logic [N_ENG-1:0] eng_start,
   input  logic [N_ENG-1:0] eng_done,
   output logic [15:0]      ich_size,
   output logic [15:0]      och_size,
   output logic [31:0]      r_addr,
   output logic [31:0]      w_addr,
   output logic             busy,
   output logic             irq,
   output logic             err,
   input  logic             irq_clr
);
   localparam int WIW = $clog2(CMD_WORDS);
   typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, DONE, ERR} state_t;
   state_t state;
   logic [WIW-1:0] widx;
   logic [7:0] op, stride;
   logic [15:0] beats;
   logic [TMO_W-1:0] tmo;
   logic [N_ENG-1:0] sel_oh;
   logic last_word, accept;
   assign cmd_rd_en = state == FETCH && !cmd_empty;
   assign opd_ready = state == ISSUE;
   assign busy = state != IDLE;
   assign accept = opd_valid && opd_ready;
   assign last_word = cmd_rd_en && widx == WIW'(CMD_WORDS - 1);
   assign sel_oh = N_ENG'(1) << (op - 8'd1);
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         widx <= '0;
         op <= '0;
         stride <= '0;
         beats <= '0;
         tmo <= '0;
         eng_data <= '0;
         eng_valid <= '0;
         eng_start <= '0;
         ich_size <= '0;
         och_size <= '0;
         r_addr <= '0;
         w_addr <= '0;
         irq <= 1'b0;
         err <= 1'b0;
      end else begin
         eng_valid <= '0;
         eng_start <= '0;
         irq <= (state == DONE || state == ERR) && !irq_clr;
         err <= state == ERR && !irq_clr;
         case (state)
            IDLE: if (op_en) state <= FETCH;
            FETCH: begin
               if (cmd_empty && widx == '0) state <= DONE;
               else if (cmd_rd_en) begin
                  widx <= last_word ? '0 : widx + 1'b1;
                  if (widx == '0) {beats, stride, op} <= cmd[31:0];
                  if (widx == WIW'(1)) {och_size, ich_size} <= cmd[31:0];
                  if (widx == WIW'(3)) r_addr <= cmd[31:0];
                  if (widx == WIW'(4)) w_addr <= cmd[31:0];
                  if (last_word) begin
                     tmo <= '0;
                     if (op == 8'd0) state <= DONE;
                     else if (op > 8'(N_ENG)) state <= ERR;
                     else if (beats == 16'd0) begin
                        state <= WAIT;
                        eng_start <= sel_oh;
                     end else state <= ISSUE;
                  end
               end
            end
            ISSUE: if (accept) begin
               eng_data <= opd_data;
               eng_valid <= sel_oh;
               r_addr <= r_addr + 32'(stride);
               beats <= beats - 16'd1;
               if (beats == 16'd1) begin
                  state <= WAIT;
                  eng_start <= sel_oh;
                  tmo <= '0;
               end
            end
            // done has priority over the terminal count
            WAIT: begin
               tmo <= tmo + 1'b1;
               if (|(eng_done & sel_oh)) state <= FETCH;
               else if (tmo == {{(TMO_W-1){1'b1}}, 1'b0}) state <= ERR;
            end
            DONE, ERR: if (irq_clr) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
